// File: rtl/lsu_dmem_master.sv
// Data-memory initiator for the LSU: one load/store in flight, word-aligned requests,
// byte lanes, load extension, alignment faults and a response timeout.
module lsu_dmem_master #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_err,
    output logic            dmem_valid,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_wen,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic             wen_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       wmask_c;
    logic [XLEN-1:0]  wdata_c;
    logic             misaligned_c;
    logic [XLEN-1:0]  shifted_c;
    logic [XLEN-1:0]  load_data_c;
    logic             timeout_hit_c;

    // Ready is combinational so it drops during reset and rises on the first cycle after.
    assign req_ready = (state == IDLE) && !rst;

    // Byte enables, lane replication and alignment check for the incoming request.
    always_comb begin
        wmask_c      = 4'b1111;
        wdata_c      = req_wdata;
        misaligned_c = 1'b0;
        case (req_size)
            2'b00: begin
                wmask_c = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wmask_c      = 4'b0011 << req_addr[1:0];
                wdata_c      = {2{req_wdata[15:0]}};
                misaligned_c = req_addr[0];
            end
            2'b10: misaligned_c = (req_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        shifted_c   = dmem_rdata >> {off_q, 3'b000};
        load_data_c = dmem_rdata;
        case (size_q)
            2'b00:   load_data_c = {{(XLEN-8){~uns_q & shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_data_c = {{(XLEN-16){~uns_q & shifted_c[15]}}, shifted_c[15:0]};
            default: ;
        endcase
    end

    assign timeout_hit_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wen_q      <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            dmem_valid <= 1'b0;
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_wmask <= 4'b0000;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q  <= req_wen;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        off_q  <= req_addr[1:0];
                        if (req_size == 2'b11) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= ERR_SIZE;
                        end else if (misaligned_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= ERR_MISALIGN;
                        end else begin
                            state      <= REQ;
                            cnt        <= '0;
                            dmem_valid <= 1'b1;
                            dmem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            dmem_wen   <= req_wen;
                            dmem_wmask <= req_wen ? wmask_c : 4'b0000;
                            dmem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem_ready && dmem_rvalid) begin
                        state      <= RESP;
                        dmem_valid <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= wen_q ? '0 : load_data_c;
                        resp_err   <= ERR_OK;
                    end else if (timeout_hit_c) begin
                        state      <= RESP;
                        dmem_valid <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                    end else if (dmem_ready) begin
                        state      <= WAIT;
                        dmem_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= wen_q ? '0 : load_data_c;
                        resp_err   <= ERR_OK;
                    end else if (timeout_hit_c) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
